// File: rtl/bundle_queue.sv
// Multi-lane bundle FIFO: up to IW enqueues and OW dequeues per cycle, flushable.
// Payload is opaque; head/tail carry an extra wrap bit so count = tail - head.
module bundle_queue #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int OW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [IW-1:0]           in_valid,
  input  logic [IW*WIDTH-1:0]     in_data,
  output logic                    in_ready,
  output logic [OW-1:0]           out_valid,
  output logic [OW*WIDTH-1:0]     out_data,
  input  logic [OW-1:0]           out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NIW = $clog2(IW) + 1;
  localparam int NOW = $clog2(OW) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    count_q, count_d;
  logic [OW-1:0]    out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [NIW-1:0]   n_in_s;
  logic [NOW-1:0]   n_out_s;
  logic             in_run_s;
  logic             out_run_s;
  logic [IW-1:0]    wr_en_s;

  // Leading-ones counts: a lane only counts if every lower lane also counts.
  always_comb begin
    n_in_s   = {NIW{1'b0}};
    in_run_s = 1'b1;
    for (int j = 0; j < IW; j++) begin
      if (in_run_s && in_valid[j]) begin
        n_in_s = n_in_s + NIW'(1);
      end else begin
        in_run_s = 1'b0;
      end
    end
    n_out_s   = {NOW{1'b0}};
    out_run_s = 1'b1;
    for (int i = 0; i < OW; i++) begin
      if (out_run_s && out_valid_q[i] && out_ready[i]) begin
        n_out_s = n_out_s + NOW'(1);
      end else begin
        out_run_s = 1'b0;
      end
    end
    for (int j = 0; j < IW; j++) begin
      wr_en_s[j] = !rst && !flush && in_ready_q && (NIW'(j) < n_in_s);
    end
  end

  // Next pointer state; flush overrides both enqueue and dequeue.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = {PW{1'b0}};
      tail_d = {PW{1'b0}};
    end else begin
      head_d = head_q + PW'(n_out_s);
      if (in_ready_q) begin
        tail_d = tail_q + PW'(n_in_s);
      end else begin
        tail_d = tail_q;
      end
    end
    count_d     = tail_d - head_d;
    out_valid_d = {OW{1'b0}};
    for (int i = 0; i < OW; i++) begin
      out_valid_d[i] = (count_d > PW'(i));
    end
    in_ready_d = ((PW'(DEPTH) - count_d) >= PW'(IW));
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {PW{1'b0}};
      out_valid_q <= {OW{1'b0}};
      in_ready_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < IW; j++) begin
      if (wr_en_s[j]) begin
        mem_q[tail_q[AW-1:0] + AW'(j)] <= in_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational read of the OW oldest entries; index wraps at DEPTH.
  always_comb begin
    out_data = {(OW*WIDTH){1'b0}};
    for (int i = 0; i < OW; i++) begin
      out_data[i*WIDTH +: WIDTH] = mem_q[head_q[AW-1:0] + AW'(i)];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

  bundle_queue_chk #(.DEPTH(DEPTH), .IW(IW), .OW(OW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .count    (count_q),
    .n_out    (n_out_s)
  );

endmodule

// Runtime invariants of bundle_queue.
module bundle_queue_chk #(
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int OW    = 4
) (
  input logic                           clk,
  input logic                           rst,
  input logic [IW-1:0]                  in_valid,
  input logic [$clog2(DEPTH):0]         count,
  input logic [$clog2(OW):0]            n_out
);

  localparam int PW = $clog2(DEPTH) + 1;

  // Occupancy bound, dequeue bound, and prefix-shaped enqueue lanes.
  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= PW'(DEPTH)) else $error("count exceeds DEPTH");
      assert (PW'(n_out) <= count) else $error("dequeue larger than occupancy");
      if ((in_valid & (in_valid + IW'(1))) != {IW{1'b0}}) begin
        $warning("in_valid is not prefix-shaped");
      end
    end
  end

endmodule

// File: tb/tb_bundle_queue.sv
// Random and directed stimulus checked every cycle against a queue-based model.
module tb_bundle_queue;

  localparam int WIDTH = 128;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int OW    = 4;
  localparam int CW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [IW-1:0]        in_valid;
  logic [IW*WIDTH-1:0]  in_data;
  logic                 in_ready;
  logic [OW-1:0]        out_valid;
  logic [OW*WIDTH-1:0]  out_data;
  logic [OW-1:0]        out_ready;
  logic [CW-1:0]        count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] q[$];
  bit track = 1'b0;
  int exp_seq = 0;

  bundle_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW*WIDTH-1:0] grp(input int a);
    logic [IW*WIDTH-1:0] d;
    for (int i = 0; i < IW; i++) d[i*WIDTH +: WIDTH] = WIDTH'(a + i);
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] lane(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  // Queue semantics: pop the ready prefix of valid lanes, push the valid prefix if there was room.
  task automatic model_update();
    int  sz;
    bit  go;
    int  nout;
    logic [WIDTH-1:0] v;
    sz = q.size();
    if (rst || flush) begin
      q.delete();
    end else begin
      nout = 0;
      go = 1'b1;
      for (int i = 0; i < OW; i++) begin
        if (go && i < sz && out_ready[i]) nout++;
        else go = 1'b0;
      end
      for (int k = 0; k < nout; k++) begin
        v = q.pop_front();
        if (track) begin
          chk("t4_order", v, WIDTH'(exp_seq));
          exp_seq++;
        end
      end
      if (DEPTH - sz >= IW) begin
        go = 1'b1;
        for (int j = 0; j < IW; j++) begin
          if (go && in_valid[j]) q.push_back(in_data[j*WIDTH +: WIDTH]);
          else go = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    int sz;
    sz = q.size();
    chk("count", WIDTH'(count), WIDTH'(sz));
    chk("in_ready", WIDTH'(in_ready), WIDTH'((DEPTH - sz) >= IW));
    for (int i = 0; i < OW; i++) begin
      chk("out_valid", WIDTH'(out_valid[i]), WIDTH'(sz > i));
      if (i < sz) chk("out_data", lane(i), q[i]);
    end
  endtask

  task automatic step(input bit f, input logic [IW-1:0] iv, input logic [IW*WIDTH-1:0] d,
                      input logic [OW-1:0] ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'b0000, grp(0), 4'b1111);
    rst = 1'b0;
  endtask

  initial begin
    int next;
    int rem;
    int sz;
    int nacc;
    logic [IW-1:0] iv;
    logic [IW*WIDTH-1:0] d;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = '0;
    in_data = '0;
    out_ready = '0;

    // 1: reset, then one full group
    do_reset();
    chk("rst_count", WIDTH'(count), WIDTH'(0));
    chk("rst_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_ready", WIDTH'(in_ready), WIDTH'(1));
    step(1'b0, 4'b1111, grp(1), 4'b0000);
    chk("t1_count", WIDTH'(count), WIDTH'(4));
    chk("t1_valid", WIDTH'(out_valid), WIDTH'(4'b1111));
    for (int i = 0; i < OW; i++) chk("t1_lane", lane(i), WIDTH'(i + 1));

    // 2: fill, then a rejected fifth group
    step(1'b0, 4'b1111, grp(5), 4'b0000);
    step(1'b0, 4'b1111, grp(9), 4'b0000);
    step(1'b0, 4'b1111, grp(13), 4'b0000);
    chk("t2_count", WIDTH'(count), WIDTH'(16));
    chk("t2_ready", WIDTH'(in_ready), WIDTH'(0));
    step(1'b0, 4'b1111, grp(100), 4'b0000);
    chk("t2_count_hold", WIDTH'(count), WIDTH'(16));
    for (int i = 0; i < OW; i++) chk("t2_lane", lane(i), WIDTH'(i + 1));

    // 3: gap in out_ready stops consumption
    step(1'b0, 4'b1111, grp(200), 4'b1011);
    chk("t3_count", WIDTH'(count), WIDTH'(14));
    chk("t3_lane0", lane(0), WIDTH'(3));
    chk("t3_valid", WIDTH'(out_valid), WIDTH'(4'b1111));

    // 4: wrap stream of 40 entries
    do_reset();
    track = 1'b1;
    exp_seq = 1;
    next = 1;
    for (int c = 0; c < 300 && exp_seq <= 40; c++) begin
      rem = 41 - next;
      if (rem > 3) rem = 3;
      iv = IW'((1 << rem) - 1);
      d = grp(next);
      sz = q.size();
      step(1'b0, iv, d, 4'b0011);
      if (DEPTH - sz >= IW) next += rem;
      chk("t4_bound", WIDTH'(count <= 16), WIDTH'(1));
    end
    track = 1'b0;
    chk("t4_done", WIDTH'(exp_seq), WIDTH'(41));

    // 5: flush beats simultaneous enqueue and dequeue
    do_reset();
    step(1'b0, 4'b1111, grp(1), 4'b0000);
    step(1'b0, 4'b1111, grp(5), 4'b0000);
    step(1'b0, 4'b0011, grp(9), 4'b0000);
    chk("t5_count10", WIDTH'(count), WIDTH'(10));
    step(1'b1, 4'b1111, grp(50), 4'b1111);
    chk("t5_count", WIDTH'(count), WIDTH'(0));
    chk("t5_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("t5_ready", WIDTH'(in_ready), WIDTH'(1));
    d = '0;
    d[WIDTH-1:0] = WIDTH'(8'hA5);
    step(1'b0, 4'b0001, d, 4'b0000);
    chk("t5_valid_a5", WIDTH'(out_valid), WIDTH'(4'b0001));
    chk("t5_lane_a5", lane(0), WIDTH'(8'hA5));

    // 6: reset with head at index 13, count 7
    do_reset();
    step(1'b0, 4'b1111, grp(1), 4'b0000);
    step(1'b0, 4'b1111, grp(5), 4'b0000);
    step(1'b0, 4'b1111, grp(9), 4'b1111);
    step(1'b0, 4'b1111, grp(13), 4'b1111);
    step(1'b0, 4'b1111, grp(17), 4'b1111);
    step(1'b0, 4'b0000, grp(0), 4'b0001);
    chk("t6_count7", WIDTH'(count), WIDTH'(7));
    chk("t6_lane0", lane(0), WIDTH'(14));
    do_reset();
    chk("t6_count", WIDTH'(count), WIDTH'(0));
    chk("t6_valid", WIDTH'(out_valid), WIDTH'(0));
    d = '0;
    d[WIDTH-1:0] = WIDTH'(8'h77);
    step(1'b0, 4'b0001, d, 4'b0000);
    chk("t6_lane", lane(0), WIDTH'(8'h77));
    chk("t6_valid1", WIDTH'(out_valid), WIDTH'(4'b0001));

    // Random traffic with occasional flush, reset and non-prefix lanes
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) < 8) iv = IW'((1 << $urandom_range(0, 4)) - 1);
      else iv = IW'($urandom_range(0, 15));
      for (int k = 0; k < IW * WIDTH / 32; k++) d[k*32 +: 32] = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 39) == 0, iv, d, OW'($urandom_range(0, 15)));
      rst = 1'b0;
    end

    nacc = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, nacc);
    $finish;
  end

endmodule
